// File: rtl/niossys_key_in_if.sv
// Avalon-MM register-bus bundle for the niosSys key/switch input port.
interface niossys_key_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/niossys_key_in.sv
// KEY/SW input port: 2-flop sync, optional debounce (NIOSSYS_KEY_IN_DEBOUNCE_EN), per-bit edge capture, maskable level irq.
// Reads are combinational with zero wait states; writes commit on the next clk edge, and the slave never stalls.
module niossys_key_in #(
  parameter int                DATA_W       = 4,
  parameter int                EDGE_POL     = 0,
  parameter int                DEBOUNCE_CYC = 50000,
  parameter logic [DATA_W-1:0] RESET_VAL    = {DATA_W{1'b1}}
) (
  input  logic                 clk,
  input  logic                 reset_n,
  niossys_key_in_if.slave      bus,
  input  logic [DATA_W-1:0]    in_port,
  output logic                 irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [DATA_W-1:0] s1;
  logic [DATA_W-1:0] s2;
  logic [DATA_W-1:0] stable;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] edges;
  logic [DATA_W-1:0] hit;
  logic [DATA_W-1:0] clr;
  logic [DATA_W-1:0] wdat;
  logic              wr_en;
  logic              unused_wdata;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wdat         = bus.writedata[DATA_W-1:0];
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

`ifdef NIOSSYS_KEY_IN_DEBOUNCE_EN
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] cnt [DATA_W];

  // A new level is accepted only after it has been seen on every one of DEBOUNCE_CYC consecutive edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= RESET_VAL;
      for (int i = 0; i < DATA_W; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DATA_W; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  localparam int UNUSED_DEBOUNCE_CYC = DEBOUNCE_CYC;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= RESET_VAL;
    end else begin
      stable <= s2;
    end
  end
`endif

  always_comb begin
    hit = '0;
    if (EDGE_POL != 0) begin
      hit = stable & ~prev;
    end else begin
      hit = prev & ~stable;
    end
  end

  assign clr = (wr_en && (bus.address == ADDR_EDGE)) ? wdat : '0;

  // Set has priority over the W1C so a coincident edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev  <= RESET_VAL;
      edges <= '0;
      mask  <= '0;
    end else begin
      prev  <= stable;
      edges <= (edges & ~clr) | hit;
      if (wr_en && (bus.address == ADDR_MASK)) begin
        mask <= wdat;
      end
    end
  end

  assign irq = |(edges & mask);

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA: bus.readdata[DATA_W-1:0] = stable;
      ADDR_MASK: bus.readdata[DATA_W-1:0] = mask;
      ADDR_EDGE: bus.readdata[DATA_W-1:0] = edges;
      default:   bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_niossys_key_in.sv
// Bench for niossys_key_in: vector table, hand-timed corner cases, then random traffic against a sample-history model.
module tb_niossys_key_in;

  localparam int DCYC = 4;
`ifdef NIOSSYS_KEY_IN_DEBOUNCE_EN
  localparam int LAT = DCYC + 2;
  localparam int WIN = DCYC;
`else
  localparam int LAT = 3;
  localparam int WIN = 1;
`endif
  localparam int PRE = (LAT > 4) ? 4 : LAT - 1;

  logic       clk;
  logic       reset_n;
  logic [3:0] in_port;
  logic       irq;
  int         n_tests;
  int         n_fail;

  niossys_key_in_if bus ();

  niossys_key_in #(
    .DATA_W      (4),
    .EDGE_POL    (0),
    .DEBOUNCE_CYC(DCYC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .in_port(in_port),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Model: a bit flips once the last WIN synchronised samples all disagree with the accepted level.
  logic [3:0] hq[$];
  logic [3:0] m_stable, m_prev, m_edge, m_mask;

  always @(posedge clk or negedge reset_n) begin
    logic [3:0] fell;
    logic [3:0] clrv;
    logic [3:0] nxt;
    logic       agree;
    if (!reset_n) begin
      hq = {};
      for (int k = 0; k <= WIN; k++) hq.push_front(4'hF);
      m_stable = 4'hF;
      m_prev   = 4'hF;
      m_edge   = 4'h0;
      m_mask   = 4'h0;
    end else begin
      fell = m_prev & ~m_stable;
      clrv = (bus.chipselect && !bus.write_n && bus.address == 2'd3) ? bus.writedata[3:0] : 4'h0;
      m_edge = (m_edge & ~clrv) | fell;
      if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask = bus.writedata[3:0];
      m_prev = m_stable;
      nxt = m_stable;
      for (int b = 0; b < 4; b++) begin
        agree = 1'b1;
        for (int j = 1; j <= WIN; j++) if (hq[j][b] == m_stable[b]) agree = 1'b0;
        if (agree) nxt[b] = ~m_stable[b];
      end
      m_stable = nxt;
      hq.push_front(in_port);
      void'(hq.pop_back());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    tick(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_data, input logic [3:0] e_mask,
                           input logic [3:0] e_edge, input logic e_irq);
    logic [31:0] d;
    rd(2'd0, d); chk({tag, ".data"}, d, {28'd0, e_data});
    rd(2'd1, d); chk({tag, ".rsvd"}, d, 32'd0);
    rd(2'd2, d); chk({tag, ".mask"}, d, {28'd0, e_mask});
    rd(2'd3, d); chk({tag, ".edge"}, d, {28'd0, e_edge});
    chk({tag, ".irq"}, {31'd0, irq}, {31'd0, e_irq});
  endtask

  typedef struct {
    logic [3:0]  in_v;
    logic        wr_en;
    logic [1:0]  waddr;
    logic [31:0] wdat;
    int          cyc;
    logic [3:0]  e_data;
    logic [3:0]  e_mask;
    logic [3:0]  e_edge;
    logic        e_irq;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] in_v, input logic w, input logic [1:0] a,
                              input logic [31:0] d, input int cyc, input logic [3:0] ed,
                              input logic [3:0] em, input logic [3:0] ee, input logic ei);
    vec_t v;
    v.in_v = in_v; v.wr_en = w; v.waddr = a; v.wdat = d; v.cyc = cyc;
    v.e_data = ed; v.e_mask = em; v.e_edge = ee; v.e_irq = ei;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    in_port = 4'hF;
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;

    tbl[0]  = mk(4'hF, 0, 2'd0, 32'h0,         1,     4'hF, 4'h0, 4'h0, 0);
    tbl[1]  = mk(4'hF, 1, 2'd2, 32'h1,         1,     4'hF, 4'h1, 4'h0, 0);
    tbl[2]  = mk(4'hE, 0, 2'd0, 32'h0,         LAT,   4'hE, 4'h1, 4'h0, 0);
    tbl[3]  = mk(4'hE, 0, 2'd0, 32'h0,         1,     4'hE, 4'h1, 4'h1, 1);
    tbl[4]  = mk(4'hE, 1, 2'd3, 32'h1,         1,     4'hE, 4'h1, 4'h0, 0);
    tbl[5]  = mk(4'hE, 1, 2'd2, 32'h0,         1,     4'hE, 4'h0, 4'h0, 0);
    tbl[6]  = mk(4'h6, 0, 2'd0, 32'h0,         LAT+1, 4'h6, 4'h0, 4'h8, 0);
    tbl[7]  = mk(4'h6, 1, 2'd2, 32'h8,         1,     4'h6, 4'h8, 4'h8, 1);
    tbl[8]  = mk(4'h6, 1, 2'd3, 32'h0,         1,     4'h6, 4'h8, 4'h8, 1);
    tbl[9]  = mk(4'h6, 1, 2'd1, 32'hF,         1,     4'h6, 4'h8, 4'h8, 1);
    tbl[10] = mk(4'hF, 0, 2'd0, 32'h0,         LAT+1, 4'hF, 4'h8, 4'h8, 1);
    tbl[11] = mk(4'hF, 1, 2'd2, 32'h0,         1,     4'hF, 4'h0, 4'h8, 0);
    tbl[12] = mk(4'hF, 1, 2'd3, 32'hF,         1,     4'hF, 4'h0, 4'h0, 0);
    tbl[13] = mk(4'hF, 1, 2'd2, 32'hF,         1,     4'hF, 4'hF, 4'h0, 0);
    tbl[14] = mk(4'h0, 0, 2'd0, 32'h0,         LAT,   4'h0, 4'hF, 4'h0, 0);
    tbl[15] = mk(4'h0, 0, 2'd0, 32'h0,         1,     4'h0, 4'hF, 4'hF, 1);
    tbl[16] = mk(4'h0, 1, 2'd3, 32'h5,         1,     4'h0, 4'hF, 4'hA, 1);
    tbl[17] = mk(4'h0, 1, 2'd3, 32'hA,         1,     4'h0, 4'hF, 4'h0, 0);
    tbl[18] = mk(4'h0, 1, 2'd2, 32'hFFFF_FFF0, 1,     4'h0, 4'h0, 4'h0, 0);
    tbl[19] = mk(4'hF, 0, 2'd0, 32'h0,         LAT+1, 4'hF, 4'h0, 4'h0, 0);

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_all("reset", 4'hF, 4'h0, 4'h0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      in_port = tbl[i].in_v;
      if (tbl[i].wr_en) begin
        wr(tbl[i].waddr, tbl[i].wdat);
        tick(tbl[i].cyc - 1);
      end else begin
        tick(tbl[i].cyc);
      end
      check_all($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_mask, tbl[i].e_edge, tbl[i].e_irq);
    end

    // Edge on bit2 lands on the same clock as a W1C of bit2.
    in_port = 4'hB;
    tick(LAT);
    check_all("coll_pre", 4'hB, 4'h0, 4'h0, 1'b0);
    wr(2'd3, 32'h4);
    check_all("coll", 4'hB, 4'h0, 4'h4, 1'b0);
    wr(2'd3, 32'h4);
    check_all("coll_clr", 4'hB, 4'h0, 4'h0, 1'b0);
    in_port = 4'hF;
    tick(LAT + 1);

`ifdef NIOSSYS_KEY_IN_DEBOUNCE_EN
    for (int r = 0; r < 5; r++) begin
      in_port = 4'hE;
      tick(3);
      in_port = 4'hF;
      tick(3);
    end
    tick(LAT + 2);
    check_all("bounce", 4'hF, 4'h0, 4'h0, 1'b0);
`endif

    // Reset lands while a new level is still being qualified.
    in_port = 4'h7;
    tick(LAT + 1);
    check_all("rst_pre", 4'h7, 4'h0, 4'h8, 1'b0);
    in_port = 4'hF;
    tick(LAT + 1);
    in_port = 4'hE;
    tick(PRE);
    check_all("rst_mid", 4'hF, 4'h0, 4'h8, 1'b0);
    reset_n = 1'b0;
    #1;
    check_all("rst_now", 4'hF, 4'h0, 4'h0, 1'b0);
    tick(1);
    reset_n = 1'b1;
    tick(LAT - 1);
    check_all("rst_hold", 4'hF, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_all("rst_acc", 4'hE, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_all("rst_edge", 4'hE, 4'h0, 4'h1, 1'b0);

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) in_port = 4'($urandom);
      if ($urandom_range(0, 3) == 0) wr(2'($urandom), $urandom);
      else tick(1);
      check_all($sformatf("rnd%0d", c), m_stable, m_mask, m_edge, |(m_edge & m_mask));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
